// File: rtl/prog_clock_divider.sv
// prog_clock_divider
// Runtime-programmable clock-enable generator. Produces a registered,
// duty-cycle-controlled waveform (clock_out) and a one-cycle period-start
// strobe (tick) from clock_in. Divisor and high-time can be reloaded at run
// time; a validated request waits in a shadow register and is applied only
// at a period boundary, or immediately while the divider is held.
//
// Handshake note: load is a single-cycle request with no back-pressure.
// It is sampled on every rising edge where it is 1. The request is either
// accepted (cfg_pending rises one cycle later) or rejected (cfg_err pulses
// one cycle later). A new accepted request replaces any request that is
// still waiting.

module prog_clock_divider #(
  parameter int WIDTH        = 28,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clock_out,
  output logic             tick,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] ZERO     = '0;

  // Counter and configuration registers
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] act_high;
  logic [WIDTH-1:0] sh_div;
  logic [WIDTH-1:0] sh_high;
  logic             pending;

  // Decoded per-cycle conditions
  logic [WIDTH-1:0] last_cnt;
  logic             period_end;
  logic             load_valid;
  logic             load_bad;
  logic             apply;
  logic             apply_hold;
  logic [WIDTH-1:0] cnt_next;
  logic             clk_next;
  logic             tick_next;

  // Decode boundary, load validity and apply conditions.
  // act_div >= 2 always holds, so act_div - 1 cannot underflow.
  always_comb begin
    last_cnt   = act_div - ONE;
    period_end = (cnt == last_cnt);
    load_valid = load && (div_in >= TWO) && (high_in <= div_in);
    load_bad   = load && !load_valid;
    apply_hold = pending && !enable;
    apply      = pending && (apply_hold || period_end);
  end

  // Next counter value and next output levels; outputs use the old config
  // even on the edge where a new config is applied at a period boundary.
  always_comb begin
    cnt_next  = cnt;
    clk_next  = clock_out;
    tick_next = 1'b0;
    if (enable) begin
      cnt_next  = period_end ? ZERO : (cnt + ONE);
      clk_next  = (cnt < act_high);
      tick_next = (cnt == ZERO) && (act_high != ZERO);
    end else if (apply_hold) begin
      cnt_next = ZERO;
      clk_next = 1'b0;
    end
  end

  // Counter and registered waveform outputs.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      cnt       <= ZERO;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      clock_out <= clk_next;
      tick      <= tick_next;
    end
  end

  // Active configuration: replaced by the shadow when an apply occurs.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      act_div  <= DEF_DIV;
      act_high <= DEF_HIGH;
    end else if (apply) begin
      act_div  <= sh_div;
      act_high <= sh_high;
    end
  end

  // Shadow configuration and pending flag; a valid load always wins over
  // the clear caused by an apply on the same edge.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sh_div  <= ZERO;
      sh_high <= ZERO;
      pending <= 1'b0;
    end else if (load_valid) begin
      sh_div  <= div_in;
      sh_high <= high_in;
      pending <= 1'b1;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  // One-cycle rejection pulse for an invalid load.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= load_bad;
    end
  end

  // Status outputs straight from state.
  always_comb begin
    cfg_pending = pending;
    cur_div     = act_div;
  end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Runtime-programmable clock divider generating a divided, duty-cycle-controlled enable waveform (`clock_out`) plus a one-cycle period-start strobe (`tick`) from a single system clock. It generalises the fixed-divisor divider used by the board-level timing logic. Divisor width is a parameter, and divisor and high-time are reloadable at run time with glitch-free, period-boundary updates. Configuration is validated, and a run/hold enable is provided. Downstream blocks (display multiplexers, debouncers, UART baud generation) consume `clock_out` or `tick` as a clock enable; neither output is used as a clock.

## Interface

Parameters:

- `WIDTH`, 28: width of the counter, divisor and high-time fields.
- `DEFAULT_DIV`, 2: divisor loaded at reset. Must be ≥ 2 and < 2^WIDTH.
- `DEFAULT_HIGH`, DEFAULT_DIV/2: high-time loaded at reset. Must be ≤ DEFAULT_DIV.

Ports:

- `clock_in`, input, 1: the single system clock. All logic runs on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset, sampled on the `clock_in` rising edge.
- `enable`, input, 1: 1 = run, 0 = hold counter and `clock_out`.
- `load`, input, 1: single-cycle request to load `div_in` and `high_in`.
- `div_in`, input, WIDTH: requested period, in `clock_in` cycles.
- `high_in`, input, WIDTH: requested number of high cycles per period.
- `clock_out`, output, 1: divided waveform, registered.
- `tick`, output, 1: one-cycle pulse marking the first high cycle of each period, registered.
- `cfg_pending`, output, 1: a validated configuration is waiting for a period boundary.
- `cfg_err`, output, 1: one-cycle pulse when a `load` is rejected.
- `cur_div`, output, WIDTH: divisor currently in effect.

## Operation

State:

- `cnt` (WIDTH bits).
- Active config: `act_div`, `act_high`.
- Shadow config: `sh_div`, `sh_high`.
- `pending` flag.

Reset (`reset_n` = 0 at an edge):

- `cnt` = 0, `act_div` = DEFAULT_DIV, `act_high` = DEFAULT_HIGH.
- Shadow cleared, `clock_out` = 0, `tick` = 0, `cfg_pending` = 0, `cfg_err` = 0.
- Reset overrides every other input, including mid-period and with a pending config. The pending config is discarded.

Counting (`enable` = 1, no apply):

- `cnt` goes to 0 if `cnt` == `act_div` − 1, else `cnt` + 1.
- `clock_out` <= (`cnt` < `act_high`).
- `tick` <= (`cnt` == 0) && (`act_high` != 0).
- Output period is exactly `act_div` cycles: `act_high` cycles high, followed by `act_div` − `act_high` cycles low.
- `act_high` = 0 gives constant low with no ticks. `act_high` = `act_div` gives constant high, with `tick` still pulsing once per period.

Hold (`enable` = 0):

- `cnt` and `clock_out` hold their values.
- `tick` = 0.

Load validation (`load` = 1 at an edge):

- Valid if and only if `div_in` ≥ 2 and `high_in` ≤ `div_in`.
- Valid load: `sh_div`/`sh_high` are written and `pending` is set.
- Invalid load: `cfg_err` = 1 for one cycle. Shadow, `pending` and the active config are unchanged.
- A valid load while already pending overwrites the shadow (last write wins) and `pending` stays 1.

Apply (`pending` = 1 at an edge):

- Condition A: `enable` = 1 and `cnt` == `act_div` − 1.
  - Active config <= shadow, `cnt` <= 0, `pending` <= 0.
  - `clock_out`/`tick` for this edge are still computed from the old config.
- Condition B: `enable` = 0.
  - Active config <= shadow, `cnt` <= 0, `clock_out` <= 0, `pending` <= 0.
- `load` at the same edge as an apply:
  - The value already in the shadow is applied.
  - The newly loaded value becomes the shadow and `pending` stays 1, so it applies at the next boundary.
  - If that load is invalid, the apply proceeds, `cfg_err` pulses and `pending` goes to 0.

Arithmetic:

- All comparisons are unsigned, WIDTH bits.
- `act_div` − 1 never underflows, because `act_div` ≥ 2 is guaranteed by validation and by the parameter constraint.

## Timing

- Outputs are registered and reflect the `cnt` value of the previous cycle, giving one cycle of latency from counter to pins.
- First edge after reset release with `enable` = 1: `clock_out` = 1 and `tick` = 1 (when DEFAULT_HIGH > 0).
- `cfg_pending` follows `load` one cycle after the accepting edge.
- `cfg_err` follows `load` one cycle after the rejecting edge.
- Condition A: the new period begins with `cnt` = 0 at the edge after the apply. The first `clock_out` under the new config appears one cycle after that.
- No runt pulses: `clock_out` changes config only at a period boundary, or while held low (Condition B).
- `cur_div` updates in the same cycle as `act_div`.

## Test plan

- **Reset defaults:** DEFAULT_DIV = 2, `enable` = 1 after reset → `clock_out` = 1,0,1,0…, `tick` = 1,0,1,0…, `cur_div` = 2.
- **Runtime reload:** load `div_in` = 5, `high_in` = 2 mid-period → `cfg_pending` = 1 until the boundary. Afterwards `clock_out` = 1,1,0,0,0 repeating, `tick` once per 5 cycles, `cur_div` = 5, no shortened period.
- **Rejection:** load `div_in` = 1, then load `div_in` = 4 with `high_in` = 5 → `cfg_err` pulses twice. `cfg_pending` stays 0 and `cur_div` is unchanged.
- **Last write wins:** two valid loads (`div_in` = 6, then `div_in` = 3 with `high_in` = 1) before a boundary → only 3/1 is applied.
- **Hold and extremes:** `enable` = 0 for 7 cycles mid-period → `cnt` and `clock_out` hold, `tick` = 0. Load while held → applied next edge with `clock_out` = 0. Then `high_in` = 0 gives constant 0 with no `tick`, and `high_in` = `div_in` = 4 gives constant 1 with `tick` every 4 cycles.
- **Reset mid-operation:** assert `reset_n` = 0 mid-period with `cfg_pending` = 1 → the next edge restores all defaults and the pending config is never applied.
